ped_signal: RTL and testbench
=============================

PED_SIGNAL -- requirements
Module: ped_signal

Interface
REQ-001 Parameter WALK_TICKS, default 6: walk interval length in tick pulses; legal range 1..15.
REQ-002 Parameter CLEAR_TICKS, default 4: flashing clearance length in tick pulses; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 light  input  3  vehicle light code from the traffic-light stage: RED=100, GREEN=010, YELLOW=001; any other value is invalid.
REQ-006 tick  input  1  one-clk-wide timing enable pulse that paces all countdowns.
REQ-007 ped_btn  input  1  raw pedestrian button level, asynchronous to clk.
REQ-008 walk  output  1  WALK lamp.
REQ-009 dont_walk  output  1  DON'T WALK lamp; solid or flashing.
REQ-010 count  output  4  countdown display; 0 when blank.
REQ-011 req_pending  output  1  latched, not-yet-served crossing request.
REQ-012 fault  output  1  invalid light code detected.

Function
REQ-013 All outputs SHALL be registered; states: IDLE, WAIT, WALK, CLEAR, FAULT.
REQ-014 Rising edge of the registered ped_btn SHALL set req_pending in IDLE, WAIT and CLEAR; presses in WALK or FAULT are ignored.
REQ-015 IDLE: walk=0, dont_walk=1, count=0; req_pending=1 -> WAIT on the next edge.
REQ-016 WAIT: outputs as IDLE; light==RED sampled -> WALK on the next edge, walk=1, dont_walk=0, count=WALK_TICKS, req_pending=0.
REQ-017 WALK: each tick decrements count; tick with count==1 -> CLEAR, count=CLEAR_TICKS, walk=0, dont_walk=1.
REQ-018 CLEAR: each tick decrements count and toggles dont_walk; tick with count==1 -> IDLE with count=0, dont_walk=1 solid.
REQ-019 light leaving RED (valid GREEN or YELLOW) while in WALK or CLEAR SHALL abort to IDLE on the next edge: walk=0, dont_walk=1, count=0; req_pending is not cleared by the abort.
REQ-020 An invalid light value sampled in any state SHALL enter FAULT on the next edge: fault=1, walk=0, dont_walk=1, count=0, req_pending=0.
REQ-021 FAULT SHALL exit to IDLE, with fault=0, on the edge after a valid light code is sampled.
REQ-022 Priority per cycle: fault > abort > tick countdown > button latch.
REQ-023 A tick in the same cycle as a WAIT->WALK transition SHALL NOT decrement the freshly loaded count.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, walk=0, dont_walk=1, count=0, req_pending=0, fault=0, and clear button synchronizer/edge flops; reset mid-WALK returns the lamps to solid DON'T WALK without finishing the interval.

Configuration
REQ-025 Macro PED_SYNC_EN defined: ped_btn passes through a two-flop synchronizer before edge detection; req_pending rises on the 3rd clk edge after ped_btn goes high.
REQ-026 PED_SYNC_EN undefined: single input register; req_pending rises on the 2nd clk edge after ped_btn goes high; all other behaviour identical.

Verification (WALK_TICKS=6, CLEAR_TICKS=4)
REQ-027 Reset release, light=GREEN, no button -> walk=0, dont_walk=1, count=0, req_pending=0 indefinitely.
REQ-028 Button pulse under GREEN, then light=RED held, 10 ticks -> WALK with count 6..1, then CLEAR with count 4..1 and dont_walk toggling 1,0,1,0, then IDLE with dont_walk=1 solid.
REQ-029 In WALK at count=3, light->GREEN -> next edge walk=0, dont_walk=1, count=0, state IDLE.
REQ-030 light=3'b110 for one cycle in WALK -> fault=1, walk=0, req_pending=0; light=RED next cycle -> fault=0 and IDLE one edge later.
REQ-031 ped_btn rise with and without PED_SYNC_EN -> req_pending high at edge 3 and edge 2 respectively.
REQ-032 rst_n low mid-CLEAR, asynchronous to clk -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/ped_signal.sv
// Pedestrian crossing controller: WAIT/WALK/CLEAR sequencing slaved to the vehicle light.
// Define PED_SYNC_EN to pass ped_btn through a two-flop synchronizer before edge detection.
module ped_signal #(
  parameter int unsigned WALK_TICKS  = 6,
  parameter int unsigned CLEAR_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light,
  input  logic       tick,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] count,
  output logic       req_pending,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WALK,
    S_CLEAR,
    S_FAULT
  } state_t;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_GREEN  = 3'b010;
  localparam logic [2:0] L_YELLOW = 3'b001;

  localparam logic [3:0] WALK_LD  = 4'(WALK_TICKS);
  localparam logic [3:0] CLEAR_LD = 4'(CLEAR_TICKS);

  state_t state;

  logic btn_now;
  logic btn_prev;
  logic btn_rise;

`ifdef PED_SYNC_EN
  logic [1:0] btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b00;
      btn_prev <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], ped_btn};
      btn_prev <= btn_sync[1];
    end
  end

  assign btn_now = btn_sync[1];
`else
  logic btn_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_reg  <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_reg  <= ped_btn;
      btn_prev <= btn_reg;
    end
  end

  assign btn_now = btn_reg;
`endif

  assign btn_rise = btn_now & ~btn_prev;

  logic is_red;
  logic is_go;
  logic is_bad;

  always_comb begin
    is_red = 1'b0;
    is_go  = 1'b0;
    is_bad = 1'b0;
    unique case (light)
      L_RED:             is_red = 1'b1;
      L_GREEN, L_YELLOW: is_go  = 1'b1;
      default:           is_bad = 1'b1;
    endcase
  end

  // Priority: invalid light first, then abort, then countdown; button latch is
  // independent of the countdown so a press during a clearance tick is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      count       <= 4'd0;
      req_pending <= 1'b0;
      fault       <= 1'b0;
    end else if (is_bad) begin
      state       <= S_FAULT;
      fault       <= 1'b1;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      count       <= 4'd0;
      req_pending <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_pending)
            state <= S_WAIT;
          if (btn_rise)
            req_pending <= 1'b1;
        end
        S_WAIT: begin
          if (is_red) begin
            state       <= S_WALK;
            walk        <= 1'b1;
            dont_walk   <= 1'b0;
            count       <= WALK_LD;
            req_pending <= 1'b0;
          end else if (btn_rise) begin
            req_pending <= 1'b1;
          end
        end
        S_WALK: begin
          if (is_go) begin
            state     <= S_IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            count     <= 4'd0;
          end else if (tick) begin
            if (count <= 4'd1) begin
              state     <= S_CLEAR;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              count     <= CLEAR_LD;
            end else begin
              count <= count - 4'd1;
            end
          end
        end
        S_CLEAR: begin
          if (is_go) begin
            state     <= S_IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            count     <= 4'd0;
          end else if (tick) begin
            if (count <= 4'd1) begin
              state     <= S_IDLE;
              dont_walk <= 1'b1;
              count     <= 4'd0;
            end else begin
              dont_walk <= ~dont_walk;
              count     <= count - 4'd1;
            end
          end
          if (btn_rise)
            req_pending <= 1'b1;
        end
        S_FAULT: begin
          state     <= S_IDLE;
          fault     <= 1'b0;
          walk      <= 1'b0;
          dont_walk <= 1'b1;
          count     <= 4'd0;
        end
        default: begin
          state     <= S_IDLE;
          walk      <= 1'b0;
          dont_walk <= 1'b1;
          count     <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_signal.sv
// Directed bench for ped_signal with a queue scoreboard of expected lamp states.
// Output vector order: {walk, dont_walk, count[3:0], req_pending, fault}.
module tb_ped_signal;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] light = 3'b010;
  logic       tick = 1'b0;
  logic       ped_btn = 1'b0;
  logic       walk;
  logic       dont_walk;
  logic [3:0] count;
  logic       req_pending;
  logic       fault;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;

`ifdef PED_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  ped_signal #(
    .WALK_TICKS (6),
    .CLEAR_TICKS(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .light      (light),
    .tick       (tick),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .count      (count),
    .req_pending(req_pending),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  wire [7:0] obs = {walk, dont_walk, count, req_pending, fault};

  function automatic logic [7:0] pk(logic w, logic d, logic [3:0] c,
                                    logic r, logic f);
    return {w, d, c, r, f};
  endfunction

  task automatic push(string t, logic [7:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.v);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic step(string t, logic [7:0] v);
    push(t, v);
    edge1();
    pop_check();
  endtask

  task automatic tstep(string t, logic [7:0] v);
    tick = 1'b1;
    push(t, v);
    edge1();
    tick = 1'b0;
    pop_check();
  endtask

  task automatic go_walk(string t);
    int n;
    n = 0;
    ped_btn = 1'b0;
    light = RED;
    repeat (3) edge1();
    ped_btn = 1'b1;
    while (walk !== 1'b1 && n < 12) begin
      edge1();
      n++;
    end
    ped_btn = 1'b0;
    total++;
    assert (walk === 1'b1) else begin
      bad++;
      $error("FAIL %s_reach: observed walk=%b expected walk=1", t, walk);
    end
    push(t, pk(1, 0, 6, 0, 0));
    pop_check();
  endtask

  initial begin
    light = GRN;
    rst_n = 1'b0;
    repeat (2) edge1();
    push("reset", pk(0, 1, 0, 0, 0));
    pop_check();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle_green", pk(0, 1, 0, 0, 0));

    ped_btn = 1'b1;
    for (int k = 1; k <= LAT; k++)
      step("btn_latency", pk(0, 1, 0, (k == LAT), 0));
    step("to_wait", pk(0, 1, 0, 1, 0));
    ped_btn = 1'b0;
    step("wait_green", pk(0, 1, 0, 1, 0));

    light = RED;
    tick = 1'b1;
    step("walk_load_tick", pk(1, 0, 6, 0, 0));
    tick = 1'b0;
    step("walk_hold", pk(1, 0, 6, 0, 0));
    for (int c = 5; c >= 1; c--) tstep("walk_cnt", pk(1, 0, 4'(c), 0, 0));
    tstep("clear_enter", pk(0, 1, 4, 0, 0));
    tstep("clear_3", pk(0, 0, 3, 0, 0));
    step("clear_hold", pk(0, 0, 3, 0, 0));
    tstep("clear_2", pk(0, 1, 2, 0, 0));
    tstep("clear_1", pk(0, 0, 1, 0, 0));
    tstep("clear_done", pk(0, 1, 0, 0, 0));
    step("idle_after", pk(0, 1, 0, 0, 0));

    go_walk("abort_walk");
    for (int c = 5; c >= 3; c--) tstep("abort_cnt", pk(1, 0, 4'(c), 0, 0));
    ped_btn = 1'b1;
    repeat (4) step("walk_btn_ignored", pk(1, 0, 3, 0, 0));
    light = GRN;
    step("abort", pk(0, 1, 0, 0, 0));
    step("abort_idle", pk(0, 1, 0, 0, 0));
    ped_btn = 1'b0;

    repeat (2) step("idle_pre_fault", pk(0, 1, 0, 0, 0));
    ped_btn = 1'b1;
    for (int k = 1; k <= LAT; k++)
      step("btn_latency2", pk(0, 1, 0, (k == LAT), 0));
    step("to_wait2", pk(0, 1, 0, 1, 0));
    ped_btn = 1'b0;
    light = 3'b111;
    step("fault_wait", pk(0, 1, 0, 0, 1));
    step("fault_hold", pk(0, 1, 0, 0, 1));
    light = GRN;
    step("fault_exit", pk(0, 1, 0, 0, 0));
    step("idle_no_req", pk(0, 1, 0, 0, 0));

    go_walk("fault_walk_entry");
    tstep("fault_walk_cnt", pk(1, 0, 5, 0, 0));
    light = 3'b110;
    step("fault_walk", pk(0, 1, 0, 0, 1));
    light = RED;
    step("fault_clear", pk(0, 1, 0, 0, 0));
    step("fault_idle", pk(0, 1, 0, 0, 0));

    go_walk("clear_entry");
    for (int c = 5; c >= 1; c--) tstep("walk_cnt2", pk(1, 0, 4'(c), 0, 0));
    tstep("clear4", pk(0, 1, 4, 0, 0));
    ped_btn = 1'b1;
    for (int k = 1; k <= LAT; k++)
      step("clear_btn", pk(0, 1, 4, (k == LAT), 0));
    ped_btn = 1'b0;
    light = GRN;
    step("clear_abort_keep_req", pk(0, 1, 0, 1, 0));
    step("abort_to_wait", pk(0, 1, 0, 1, 0));
    light = RED;
    step("wait_to_walk3", pk(1, 0, 6, 0, 0));
    for (int c = 5; c >= 1; c--) tstep("walk_cnt3", pk(1, 0, 4'(c), 0, 0));
    tstep("clear4b", pk(0, 1, 4, 0, 0));
    tstep("clear3b", pk(0, 0, 3, 0, 0));

    #3;
    rst_n = 1'b0;
    #1;
    push("async_reset", pk(0, 1, 0, 0, 0));
    pop_check();
    edge1();
    step("reset_held", pk(0, 1, 0, 0, 0));
    rst_n = 1'b1;
    step("post_reset", pk(0, 1, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
